jtag_host_driver: RTL and testbench

//  Host-side JTAG initiator that drives the chip's JTAG pins (tck/tms/tdi/trst_n) and samples tdo.

---
 rtl/jtag_host_driver.sv | 189 ++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_driver.sv
// Host-side JTAG initiator: walks the TAP through IR/DR scans or a TAP reset, shifts cmd_data out
// on tdi and returns the tdo bits captured during the shift.
module jtag_host_driver #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  output logic               jtag_trst_n,
  input  logic               jtag_tdo
);

  localparam int unsigned      DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned      IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_LEN);
  localparam logic [1:0]       TypeIr  = 2'd0;
  localparam logic [1:0]       TypeDr  = 2'd1;
  localparam logic [1:0]       TypeRst = 2'd2;
  localparam logic [1:0]       TypeBad = 2'd3;

  typedef enum logic [2:0] {StInit, StIdle, StHdr, StShift, StUpd, StRti, StDone} state_e;

  state_e             state_q;
  logic [DivW-1:0]    div_q;
  logic [LEN_W-1:0]   bit_q;
  logic [1:0]         type_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;

  logic             running, tick, rise, fall, shift_last;
  logic [LEN_W-1:0] bit_nxt, hdr_last;
  logic [IdxW-1:0]  idx, idx_nxt;

  assign running    = state_q inside {StInit, StHdr, StShift, StUpd, StRti};
  assign tick       = running && (div_q == DivLast);
  assign rise       = tick && !jtag_tck;
  assign fall       = tick && jtag_tck;
  assign bit_nxt    = bit_q + LEN_W'(1);
  assign idx        = bit_q[IdxW-1:0];
  assign idx_nxt    = bit_nxt[IdxW-1:0];
  assign shift_last = (bit_q == len_q - LEN_W'(1));

  // Index of the last tms header bit for the latched command type.
  always_comb begin
    hdr_last = LEN_W'(4);
    if (type_q == TypeIr) begin
      hdr_last = LEN_W'(3);
    end else if (type_q == TypeDr) begin
      hdr_last = LEN_W'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      div_q       <= '0;
      bit_q       <= '0;
      type_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      jtag_tck    <= 1'b0;
      jtag_tms    <= 1'b1;
      jtag_tdi    <= 1'b0;
      jtag_trst_n <= 1'b0;
    end else begin
      jtag_trst_n <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;

      if (running) begin
        if (tick) begin
          div_q    <= '0;
          jtag_tck <= ~jtag_tck;
        end else begin
          div_q <= div_q + DivW'(1);
        end
      end else begin
        div_q    <= '0;
        jtag_tck <= 1'b0;
      end

      // tms/tdi only move on tck falling edges so the TAP sees them stable at its rising edge.
      unique case (state_q)
        StInit: begin
          if (fall) begin
            if (bit_q == LEN_W'(5)) begin
              state_q   <= StIdle;
              cmd_ready <= 1'b1;
              bit_q     <= '0;
              jtag_tms  <= 1'b0;
            end else begin
              bit_q    <= bit_nxt;
              jtag_tms <= (bit_nxt < LEN_W'(5));
            end
          end
        end
        StIdle: begin
          jtag_tms <= 1'b0;
          jtag_tdi <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            type_q    <= cmd_type;
            len_q     <= cmd_len;
            data_q    <= cmd_data;
            rsp_data  <= '0;
            bit_q     <= '0;
            if (cmd_len == '0 || cmd_len > MaxLen || cmd_type == TypeBad) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state_q  <= StHdr;
              jtag_tms <= 1'b1;
            end
          end
        end
        StHdr: begin
          if (fall) begin
            if (bit_q == hdr_last) begin
              bit_q <= '0;
              if (type_q == TypeRst) begin
                state_q  <= StRti;
                jtag_tms <= 1'b0;
              end else begin
                state_q  <= StShift;
                jtag_tms <= (len_q == LEN_W'(1));
                jtag_tdi <= data_q[0];
              end
            end else begin
              bit_q    <= bit_nxt;
              jtag_tms <= (type_q == TypeRst) || (type_q == TypeIr && bit_q == '0);
            end
          end
        end
        StShift: begin
          if (rise) begin
            rsp_data[idx] <= jtag_tdo;
          end
          if (fall) begin
            if (shift_last) begin
              state_q  <= StUpd;
              jtag_tms <= 1'b1;
              jtag_tdi <= 1'b0;
            end else begin
              bit_q    <= bit_nxt;
              jtag_tdi <= data_q[idx_nxt];
              jtag_tms <= (bit_nxt == len_q - LEN_W'(1));
            end
          end
        end
        StUpd: begin
          if (fall) begin
            state_q  <= StRti;
            jtag_tms <= 1'b0;
          end
        end
        StRti: begin
          if (fall) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver: a behavioural TAP (8-bit IR capturing 0x05, 1-bit bypass DR) answers
// the driver; responses, tms streams and latencies are predicted from the scan rules.
module tb_jtag_host_driver;
  localparam int unsigned C  = 2;
  localparam int unsigned ML = 64;
  localparam int unsigned LW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_type = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [ML-1:0] cmd_data = '0;
  logic          cmd_ready, rsp_valid, rsp_err;
  logic [ML-1:0] rsp_data;
  logic          jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
  logic          tap_tdo = 1'b0;

  jtag_host_driver #(.CLK_DIV(C), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_trst_n(jtag_trst_n), .jtag_tdo(tap_tdo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // IEEE 1149.1 TAP: 0 TLR, 1 RTI, 2..8 DR column, 9..15 IR column.
  int         tap_st = 0;
  logic       dr_bp = 1'b0;
  logic [7:0] ir_sh = '0;

  function automatic int tap_next(input int s, input logic tms);
    case (s)
      0: return tms ? 0 : 1;    1: return tms ? 2 : 1;
      2: return tms ? 9 : 3;    3: return tms ? 5 : 4;
      4: return tms ? 5 : 4;    5: return tms ? 8 : 6;
      6: return tms ? 7 : 6;    7: return tms ? 8 : 4;
      8: return tms ? 2 : 1;    9: return tms ? 0 : 10;
      10: return tms ? 12 : 11; 11: return tms ? 12 : 11;
      12: return tms ? 15 : 13; 13: return tms ? 14 : 13;
      14: return tms ? 15 : 11; 15: return tms ? 2 : 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge jtag_tck or negedge jtag_trst_n) begin
    if (!jtag_trst_n) begin
      tap_st <= 0;
    end else begin
      case (tap_st)
        3:  dr_bp <= 1'b0;
        4:  dr_bp <= jtag_tdi;
        10: ir_sh <= 8'h05;
        11: ir_sh <= {jtag_tdi, ir_sh[7:1]};
        default: ;
      endcase
      tap_st <= tap_next(tap_st, jtag_tms);
    end
  end

  always @(negedge jtag_tck) tap_tdo <= (tap_st == 4) ? dr_bp : (tap_st == 11) ? ir_sh[0] : 1'b0;

  logic tms_log[$];
  logic tdi_log[$];
  int   n_rise = 0;
  int   n_fall = 0;
  int   n_rsp = 0;

  always @(posedge jtag_tck) begin
    tms_log.push_back(jtag_tms);
    tdi_log.push_back(jtag_tdi);
    n_rise <= n_rise + 1;
  end
  always @(negedge jtag_tck) n_fall <= n_fall + 1;
  always @(posedge clk) n_rsp <= n_rsp + int'(rsp_valid);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] pack_log(input int start, input int n, input bit use_tdi);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n && i < 128; i++) v[i] = use_tdi ? tdi_log[start+i] : tms_log[start+i];
    return v;
  endfunction

  // tdo stream of a shift register of length L: its capture value first, then tdi delayed by L.
  function automatic logic [ML-1:0] exp_rsp(input int t, input int len, input logic [ML-1:0] d);
    logic [ML-1:0] r;
    logic [7:0]    cap;
    int            l;
    r = '0;
    if (t == 0) begin l = 8; cap = 8'h05; end
    else if (t == 1) begin l = 1; cap = 8'h00; end
    else return r;
    for (int i = 0; i < len; i++) r[i] = (i < l) ? cap[i] : d[i-l];
    return r;
  endfunction

  function automatic int tck_count(input int t, input int len);
    return (t == 0) ? len + 6 : (t == 1) ? len + 5 : 6;
  endfunction

  function automatic logic [127:0] exp_tms(input int t, input int len);
    logic [127:0] v;
    int k;
    v = '0;
    k = 0;
    if (t == 2) begin
      v[4:0] = 5'h1f;
      return v;
    end
    v[k] = 1'b1; k++;
    if (t == 0) begin v[k] = 1'b1; k++; end
    k += 2 + len - 1;
    v[k] = 1'b1; k++;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 5000) begin @(negedge clk); guard++; end
    chk({tag, "/ready"}, cmd_ready, 1);
  endtask

  // Waits for rsp_valid; cyc counts negedges after the accept edge (starts at 1).
  task automatic wait_rsp(inout int cyc);
    while (rsp_valid !== 1'b1 && cyc < 5000) begin @(negedge clk); cyc++; end
  endtask

  task automatic check_rsp(input string tag, input int t, input int len, input logic [ML-1:0] d,
                           input int cyc, input int r0, input int f0, input int q0);
    bit           err;
    int           n, hdr;
    logic [127:0] tv, dv;
    err = (len == 0) || (len > ML) || (t == 3);
    n = err ? 0 : tck_count(t, len);
    chk({tag, "/lat"}, cyc, err ? 1 : n * 2 * C + 1);
    chk({tag, "/err"}, rsp_err, err);
    chk({tag, "/data"}, rsp_data, err ? '0 : exp_rsp(t, len, d));
    chk({tag, "/rises"}, n_rise - r0, n);
    chk({tag, "/falls"}, n_fall - f0, n);
    if (!err) begin
      chk({tag, "/tms"}, pack_log(q0, n, 1'b0), exp_tms(t, len));
      if (t != 2) begin
        hdr = (t == 0) ? 4 : 3;
        dv = '0;
        for (int i = 0; i < len; i++) dv[i] = d[i];
        tv = pack_log(q0 + hdr, len, 1'b1);
        chk({tag, "/tdi"}, tv, dv);
      end
    end
  endtask

  task automatic do_cmd(input string tag, input int t, input int len, input logic [ML-1:0] d);
    int r0, f0, q0, cyc;
    wait_ready(tag);
    r0 = n_rise; f0 = n_fall; q0 = tms_log.size();
    cmd_valid = 1'b1; cmd_type = t[1:0]; cmd_len = len[LW-1:0]; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    wait_rsp(cyc);
    check_rsp(tag, t, len, d, cyc, r0, f0, q0);
    @(negedge clk);
    chk({tag, "/pulse"}, rsp_valid, 0);
    chk({tag, "/idle"}, {cmd_ready, jtag_tck}, 2'b10);
    chk({tag, "/tap"}, tap_st, 1);
  endtask

  task automatic init_check(input string tag);
    int r0, q0, cyc;
    r0 = n_rise; q0 = tms_log.size();
    rst = 1'b0;
    @(negedge clk);
    cyc = 1;
    chk({tag, "/trst"}, jtag_trst_n, 1);
    while (cmd_ready !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk({tag, "/ready_at"}, cyc, 12 * C);
    chk({tag, "/rises"}, n_rise - r0, 6);
    chk({tag, "/tms"}, pack_log(q0, 6, 1'b0), 128'h1f);
    chk({tag, "/tap"}, tap_st, 1);
    chk({tag, "/tck"}, jtag_tck, 0);
  endtask

  initial begin
    logic [ML-1:0] d, da, db;
    int            r0, f0, q0, cyc, busy_bad, t, len, rsp0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/tck", jtag_tck, 0);
    chk("rst/tms", jtag_tms, 1);
    chk("rst/tdi", jtag_tdi, 0);
    chk("rst/trst", jtag_trst_n, 0);
    chk("rst/ready", cmd_ready, 0);
    chk("rst/rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst/data", rsp_data, 0);
    init_check("init");

    do_cmd("ir6", 0, 6, 64'h28);
    d = {$urandom, $urandom};
    do_cmd("dr64", 1, 64, d);
    repeat (3) @(negedge clk);
    chk("dr64/hold", rsp_data, {d[62:0], 1'b0});

    do_cmd("err_len0", 1, 0, 64'hffff);
    do_cmd("err_len65", 0, 65, 64'hffff);
    do_cmd("err_len127", 1, 127, 64'h1);
    do_cmd("err_type3", 3, 5, 64'h1f);
    do_cmd("tapreset", 2, 7, {$urandom, $urandom});
    do_cmd("ir1", 0, 1, 64'h1);
    do_cmd("dr1", 1, 1, 64'h1);
    do_cmd("ir64", 0, 64, {$urandom, $urandom});

    for (int i = 0; i < 10; i++) begin
      t = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, ML));
      do_cmd($sformatf("rand%0d", i), t, len, {$urandom, $urandom});
    end

    // Command held valid through a busy DR scan; a second command waits behind it.
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    wait_ready("busy");
    r0 = n_rise; f0 = n_fall; q0 = tms_log.size();
    cmd_valid = 1'b1; cmd_type = 2'd1; cmd_len = LW'(20); cmd_data = da;
    @(negedge clk);
    cmd_type = 2'd0; cmd_len = LW'(12); cmd_data = db;
    busy_bad = 0;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 5000) begin
      if (cmd_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    chk("busy/ready_low", busy_bad, 0);
    chk("busy/ready_done", cmd_ready, 0);
    check_rsp("busyA", 1, 20, da, cyc, r0, f0, q0);
    @(negedge clk);
    chk("busy/ready_idle", {cmd_ready, jtag_tck}, 2'b10);
    r0 = n_rise; f0 = n_fall; q0 = tms_log.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy/accepted", {cmd_ready, jtag_tck, rsp_valid}, 3'b000);
    chk("busy/data_clr", rsp_data, 0);
    cyc = 1;
    wait_rsp(cyc);
    check_rsp("busyB", 0, 12, db, cyc, r0, f0, q0);

    // Reset during shift bit 10 of a DR scan.
    wait_ready("rstmid");
    r0 = n_rise;
    cmd_valid = 1'b1; cmd_type = 2'd1; cmd_len = LW'(40); cmd_data = {$urandom, $urandom};
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (n_rise - r0 < 3 + 11 && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("rstmid/reach", n_rise - r0, 14);
    rsp0 = n_rsp;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid/pins", {jtag_tck, jtag_tms, jtag_trst_n}, 3'b010);
    chk("rstmid/out", {cmd_ready, rsp_valid, rsp_err}, 3'b000);
    chk("rstmid/data", rsp_data, 0);
    @(negedge clk);
    init_check("reinit");
    chk("rstmid/no_rsp", n_rsp - rsp0, 0);
    do_cmd("post_rst", 1, 9, {$urandom, $urandom});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
